// File: rtl/uart_send.sv
// 8N1/8E1/8O1 UART transmitter, LSB first; start bit drives on the edge after accept, each bit BPS_CNT cycles.
// Backpressure: tx_ready only in IDLE (including the done cycle); tx_valid at any other time is dropped.
module uart_send #(
  parameter logic [15:0] BPS_CNT    = 16'd434,
  parameter logic        PARITY_EN  = 1'b0,
  parameter logic        PARITY_ODD = 1'b0
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       uart_txd,
  output logic       tx_busy,
  output logic       tx_byte_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t      r_state;
  logic [15:0] r_clk_cnt;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shreg;
  logic        r_par;
  logic        r_txd;
  logic        r_busy;
  logic        r_done;

  logic w_accept;
  logic w_bit_end;

  assign tx_ready     = (r_state == S_IDLE);
  assign w_accept     = tx_valid && tx_ready;
  assign w_bit_end    = (r_clk_cnt == BPS_CNT - 16'd1);
  assign uart_txd     = r_txd;
  assign tx_busy      = r_busy;
  assign tx_byte_done = r_done;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= S_IDLE;
      r_clk_cnt <= 16'd0;
      r_bit_cnt <= 3'd0;
      r_shreg   <= 8'd0;
      r_par     <= 1'b0;
      r_txd     <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_txd     <= 1'b1;
          r_clk_cnt <= 16'd0;
          r_bit_cnt <= 3'd0;
          if (w_accept) begin
            // Parity is taken from the byte as accepted; the shift register is consumed during DATA.
            r_state <= S_START;
            r_shreg <= tx_data;
            r_par   <= (^tx_data) ^ PARITY_ODD;
            r_txd   <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_clk_cnt <= 16'd0;
            r_state   <= S_DATA;
            r_txd     <= r_shreg[0];
          end else begin
            r_clk_cnt <= r_clk_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_clk_cnt <= 16'd0;
            r_shreg   <= r_shreg >> 1;
            if (r_bit_cnt == 3'd7) begin
              if (PARITY_EN) begin
                r_state <= S_PARITY;
                r_txd   <= r_par;
              end else begin
                r_state <= S_STOP;
                r_txd   <= 1'b1;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_txd     <= r_shreg[1];
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 16'd1;
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_clk_cnt <= 16'd0;
            r_state   <= S_STOP;
            r_txd     <= 1'b1;
          end else begin
            r_clk_cnt <= r_clk_cnt + 16'd1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_clk_cnt <= 16'd0;
            r_bit_cnt <= 3'd0;
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end else begin
            r_clk_cnt <= r_clk_cnt + 16'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_txd   <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_send.sv
// Bench for uart_send: four instances (434/8N1, 8/8E1, 8/8O1, 2/8N1) each watched by a receiver-model monitor.
// Stimulus pushes the expected byte; the monitor decodes each frame off the line and checks it.
module tb_uart_send;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       vld  [4];
  logic [7:0] dat  [4];
  logic       rdy  [4];
  logic       txd  [4];
  logic       busy [4];
  logic       done [4];

  uart_send #(.BPS_CNT(16'd434), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_main (
    .sys_clk(clk), .sys_rst_n(rst_n), .tx_valid(vld[0]), .tx_data(dat[0]),
    .tx_ready(rdy[0]), .uart_txd(txd[0]), .tx_busy(busy[0]), .tx_byte_done(done[0]));
  uart_send #(.BPS_CNT(16'd8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_even (
    .sys_clk(clk), .sys_rst_n(rst_n), .tx_valid(vld[1]), .tx_data(dat[1]),
    .tx_ready(rdy[1]), .uart_txd(txd[1]), .tx_busy(busy[1]), .tx_byte_done(done[1]));
  uart_send #(.BPS_CNT(16'd8), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_odd (
    .sys_clk(clk), .sys_rst_n(rst_n), .tx_valid(vld[2]), .tx_data(dat[2]),
    .tx_ready(rdy[2]), .uart_txd(txd[2]), .tx_busy(busy[2]), .tx_byte_done(done[2]));
  uart_send #(.BPS_CNT(16'd2), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_fast (
    .sys_clk(clk), .sys_rst_n(rst_n), .tx_valid(vld[3]), .tx_data(dat[3]),
    .tx_ready(rdy[3]), .uart_txd(txd[3]), .tx_busy(busy[3]), .tx_byte_done(done[3]));

  typedef struct {
    int         idx;
    logic [7:0] dat;
    logic       par;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   acc_cyc   [4] = '{default: 0};
  int   done_last [4] = '{default: 0};
  int   done_prev [4] = '{default: 0};
  int   done_cnt  [4] = '{default: 0};

  always @(posedge clk) cyc <= cyc + 1;

  // Accepts and done pulses are stamped with the index of the posedge that samples them.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (vld[i] && rdy[i]) acc_cyc[i] <= cyc + 1;
      if (done[i]) begin
        done_prev[i] <= done_last[i];
        done_last[i] <= cyc + 1;
        done_cnt[i]  <= done_cnt[i] + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  task automatic mon(input int idx, input int bps, input bit pen);
    int          nb;
    logic [10:0] bits;
    bit          wbad;
    bit          abort;
    exp_t        e;
    nb = pen ? 11 : 10;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && txd[idx] === 1'b0) begin
        bits  = '0;
        wbad  = 1'b0;
        abort = 1'b0;
        if (exp_q.size() == 0) begin
          e.idx = -1; e.dat = 8'h00; e.par = 1'b0;
        end else begin
          e = exp_q.pop_front();
        end
        for (int b = 0; b < nb && !abort; b++) begin
          for (int s = 0; s < bps && !abort; s++) begin
            if (b != 0 || s != 0) @(negedge clk);
            if (rst_n !== 1'b1) abort = 1'b1;
            else if (s == 0) bits[b] = txd[idx];
            else if (txd[idx] !== bits[b]) wbad = 1'b1;
          end
        end
        if (!abort) begin
          @(negedge clk);
          if (rst_n !== 1'b1) abort = 1'b1;
        end
        if (abort) begin
          while (rst_n !== 1'b1 || txd[idx] !== 1'b1) @(negedge clk);
        end else begin
          chk("frame_instance", 32'(e.idx), 32'(idx));
          chk("frame_byte", 32'(bits[8:1]), 32'(e.dat));
          chk("bit_width", 32'(wbad), 32'd0);
          chk("stop_bit", 32'(bits[nb-1]), 32'd1);
          if (pen) chk("parity_bit", 32'(bits[9]), 32'(e.par));
          chk("done_after_stop", 32'(done[idx]), 32'd1);
        end
      end
    end
  endtask

  initial begin
    fork
      mon(0, 434, 1'b0);
      mon(1, 8, 1'b1);
      mon(2, 8, 1'b1);
      mon(3, 2, 1'b0);
    join_none
  end

  task automatic send(input int i, input logic [7:0] d, input logic par);
    exp_t e;
    bit   ok;
    e.idx = i; e.dat = d; e.par = par;
    exp_q.push_back(e);
    @(posedge clk); #1;
    vld[i] = 1'b1;
    dat[i] = d;
    ok = 1'b0;
    for (int k = 0; k < 20000 && !ok; k++) begin
      @(negedge clk);
      if (rdy[i]) ok = 1'b1;
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    vld[i] = 1'b0;
    dat[i] = ~d;
  endtask

  task automatic wait_done(input int i, input int target);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 20000 && !ok; k++) begin
      @(negedge clk);
      if (done_cnt[i] >= target) ok = 1'b1;
    end
    if (!ok) chk("done_timeout", 32'(done_cnt[i]), 32'(target));
    @(negedge clk);
  endtask

  int  n;
  bit  ok;

  initial begin
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vld[i] = 1'b0;
      dat[i] = 8'h00;
    end
    #1 rst_n = 1'b0;
    #1;
    chk("rst_txd", 32'(txd[0]), 32'd1);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_done", 32'(done[0]), 32'd0);
    chk("rst_ready", 32'(rdy[0]), 32'd1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 0x55 at 434 cycles/bit: done sampled 10*434+1 edges after the accepting edge.
    n = done_cnt[0];
    send(0, 8'h55, 1'b0);
    wait_done(0, n + 1);
    chk("t1_done_latency", 32'(done_last[0] - acc_cyc[0]), 32'd4341);
    chk("t1_done_count", 32'(done_cnt[0] - n), 32'd1);

    // 0xA3 with parity: four ones, so even parity 0 and odd parity 1.
    send(1, 8'hA3, 1'b0);
    wait_done(1, 1);
    send(2, 8'hA3, 1'b1);
    wait_done(2, 1);

    // Back-to-back 0x00 then 0xFF with tx_valid held high.
    n = done_cnt[0];
    exp_q.push_back('{idx: 0, dat: 8'h00, par: 1'b0});
    exp_q.push_back('{idx: 0, dat: 8'hFF, par: 1'b0});
    @(posedge clk); #1;
    vld[0] = 1'b1;
    dat[0] = 8'h00;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (rdy[0]) ok = 1'b1;
    end
    @(posedge clk); #1;
    dat[0] = 8'hFF;
    ok = 1'b0;
    for (int k = 0; k < 20000 && !ok; k++) begin
      @(negedge clk);
      if (rdy[0]) ok = 1'b1;
    end
    chk("t3_ready_with_done", 32'(done[0]), 32'd1);
    @(posedge clk); #1;
    vld[0] = 1'b0;
    wait_done(0, n + 2);
    chk("t3_done_spacing", 32'(done_last[0] - done_prev[0]), 32'd4341);
    chk("t3_done_count", 32'(done_cnt[0] - n), 32'd2);

    // tx_valid pulse with 0x12 mid-frame must be dropped.
    n = done_cnt[0];
    send(0, 8'h3C, 1'b0);
    repeat (1000) @(posedge clk);
    #1;
    chk("t4_ready_midframe", 32'(rdy[0]), 32'd0);
    vld[0] = 1'b1;
    dat[0] = 8'h12;
    @(posedge clk); #1;
    vld[0] = 1'b0;
    wait_done(0, n + 1);
    repeat (500) @(posedge clk);
    chk("t4_done_count", 32'(done_cnt[0] - n), 32'd1);
    chk("t4_busy_after", 32'(busy[0]), 32'd0);

    // Reset during D3 of 0x0F abandons the frame; the next frame is clean.
    n = done_cnt[0];
    send(0, 8'h0F, 1'b0);
    repeat (4 * 434 + 200) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_txd_in_reset", 32'(txd[0]), 32'd1);
    chk("t5_busy_in_reset", 32'(busy[0]), 32'd0);
    chk("t5_ready_in_reset", 32'(rdy[0]), 32'd1);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (50) @(posedge clk);
    chk("t5_no_done", 32'(done_cnt[0] - n), 32'd0);
    chk("t5_line_idle", 32'(txd[0]), 32'd1);
    send(0, 8'hC5, 1'b0);
    wait_done(0, n + 1);
    chk("t5_clean_done", 32'(done_cnt[0] - n), 32'd1);

    // Every byte value through the 2-cycles-per-bit instance.
    for (int b = 0; b < 256; b++) begin
      send(3, 8'(b), 1'b0);
      wait_done(3, b + 1);
    end
    chk("t6_done_count", 32'(done_cnt[3]), 32'd256);

    repeat (20) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
